// File: rtl/nav_button_events_pkg.sv
// Shared definitions for the colour-matching game input path: direction and
// arbiter state encodings, the system clock constant and the priority helpers.
package game_pkg;

    localparam int CLK_HZ = 25_000_000;

    // Default cycle counts derived from the 25 MHz clock.
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;    // 10 ms
    localparam int REPEAT_DELAY_DEF    = CLK_HZ / 2;      // 500 ms
    localparam int REPEAT_PERIOD_DEF   = CLK_HZ / 5;      // 200 ms

    // Bit index of each direction in the 4-bit button vectors.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        RIGHT = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FIRE = 2'b01,
        HELD = 2'b10
    } nav_state_t;

    // Priority order up > down > right > left.
    function automatic dir_t pick_winner(logic [3:0] edges);
        if (edges[0])      return UP;
        else if (edges[1]) return DOWN;
        else if (edges[2]) return RIGHT;
        else               return LEFT;
    endfunction

    function automatic logic [3:0] dir_onehot(dir_t d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/nav_button_events_if.sv
// Button/move bundle between the board buttons, the game sequencer and
// nav_button_events.
interface nav_button_events_if;
    logic en;
    logic btn_up_raw;
    logic btn_down_raw;
    logic btn_right_raw;
    logic btn_left_raw;
    logic up;
    logic down;
    logic right;
    logic left;
    logic held;

    modport master (
        output en, btn_up_raw, btn_down_raw, btn_right_raw, btn_left_raw,
        input  up, down, right, left, held
    );

    modport slave (
        input  en, btn_up_raw, btn_down_raw, btn_right_raw, btn_left_raw,
        output up, down, right, left, held
    );
endinterface

// File: rtl/nav_button_events_debounce_cell.sv
// One button: two-flop synchroniser, stable-level debouncer and registered
// 0->1 press-edge pulse.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            // Any return to the stable level restarts the window.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;
endmodule

// File: rtl/nav_button_events.sv
// Four debounced buttons -> mutually exclusive one-cycle move pulses.
// Optional auto-repeat while a single button is held: define AUTO_REPEAT_EN.
module nav_button_events
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 18,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic         clk25MHz,
    input  logic         rst_n,
    nav_button_events_if.slave nav
);
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << CNT_W) - 1) begin : g_cfg_db_err
        $error("nav_button_events: DEBOUNCE_CYCLES must be in 2 .. 2**CNT_W-1");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_cfg_rpt_err
        $error("nav_button_events: repeat delay/period must be at least 2");
    end

    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    // Async assert, synchronous release for everything downstream.
    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    logic [3:0] w_raw;
    logic [3:0] w_level;
    logic [3:0] w_press;

    assign w_raw = {nav.btn_left_raw, nav.btn_right_raw, nav.btn_down_raw, nav.btn_up_raw};

    debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_cell [3:0] (
        .clk    (clk25MHz),
        .rst_n  (w_rst_n),
        .i_raw  (w_raw),
        .o_level(w_level),
        .o_press(w_press)
    );

    nav_state_t r_state;
    logic [3:0] r_move;
    logic       r_held;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);

    dir_t             r_dir;
    logic             r_rep_first;
    logic [3:0]       r_level_d;
    logic [RPT_W-1:0] r_rep_cnt;
    logic             w_rep_run;
    logic [RPT_W-1:0] w_rep_lim;

    // Counter runs only while the last fired button is the sole, unchanged press.
    assign w_rep_run = nav.en && (r_state == HELD) && (w_level == dir_onehot(r_dir))
                       && (w_level == r_level_d);
    assign w_rep_lim = r_rep_first ? RPT_W'(REPEAT_DELAY - 2) : RPT_W'(REPEAT_PERIOD - 2);
`endif

    always_ff @(posedge clk25MHz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
            r_move  <= '0;
            r_held  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            r_dir       <= UP;
            r_rep_first <= 1'b1;
            r_level_d   <= '0;
            r_rep_cnt   <= '0;
`endif
        end else begin
            r_held <= |w_level;
            r_move <= '0;
            if (!nav.en) begin
                r_state <= (|w_level) ? HELD : IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (|w_press) begin
                            r_state <= FIRE;
                            r_move  <= dir_onehot(pick_winner(w_press));
`ifdef AUTO_REPEAT_EN
                            r_dir <= pick_winner(w_press);
`endif
                        end
                    end
                    FIRE: r_state <= HELD;
                    HELD: begin
                        if (~|w_level) begin
                            r_state <= IDLE;
`ifdef AUTO_REPEAT_EN
                        end else if (w_rep_run && r_rep_cnt == w_rep_lim) begin
                            r_state <= FIRE;
                            r_move  <= dir_onehot(r_dir);
`endif
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
`ifdef AUTO_REPEAT_EN
            r_level_d <= w_level;
            if (w_rep_run && r_rep_cnt != w_rep_lim) r_rep_cnt <= r_rep_cnt + 1'b1;
            else                                     r_rep_cnt <= '0;
            // First repeat waits the long delay; later ones use the period.
            if (r_state == IDLE || w_level != r_level_d || !nav.en)
                r_rep_first <= 1'b1;
            else if (w_rep_run && r_rep_cnt == w_rep_lim)
                r_rep_first <= 1'b0;
`endif
        end
    end

    // Dropping en kills a pulse in the very cycle it is presented.
    assign nav.up    = r_move[0] & nav.en;
    assign nav.down  = r_move[1] & nav.en;
    assign nav.right = r_move[2] & nav.en;
    assign nav.left  = r_move[3] & nav.en;
    assign nav.held  = r_held;
endmodule

// File: tb/tb_nav_button_events.sv
// Scoreboard bench for nav_button_events: stimulus pushes expected pulses
// (edge number + direction); a negedge monitor pops and compares.
module tb_nav_button_events;
    import game_pkg::*;

    logic clk25MHz = 1'b0;
    logic rst_n    = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;

    typedef struct {
        int         c;
        logic [3:0] mv;
    } exp_t;
    exp_t exp_q[$];

    nav_button_events_if nav();

    nav_button_events #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk25MHz(clk25MHz),
        .rst_n   (rst_n),
        .nav     (nav)
    );

    always #20 clk25MHz = ~clk25MHz;
    always @(posedge clk25MHz) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic goto(input int k);
        while (cyc < k) @(negedge clk25MHz);
    endtask

    task automatic expect_mv(input int c, input logic [3:0] mv);
        exp_t e;
        e.c  = c;
        e.mv = mv;
        exp_q.push_back(e);
    endtask

    // Monitor: any move output high must match the head of the queue.
    always @(negedge clk25MHz) begin
        logic [3:0] mv;
        exp_t e;
        mv = {nav.left, nav.right, nav.down, nav.up};
        if (mv != 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d got=%b want=none", cyc, mv);
            end else begin
                e = exp_q.pop_front();
                if (e.mv != mv || e.c != cyc) begin
                    errors++;
                    $display("FAIL pulse cyc=%0d got=%b want=%b@%0d", cyc, mv, e.mv, e.c);
                end
            end
        end
    end

    initial begin
        nav.en            = 1'b1;
        nav.btn_up_raw    = 1'b0;
        nav.btn_down_raw  = 1'b0;
        nav.btn_right_raw = 1'b0;
        nav.btn_left_raw  = 1'b0;

        // Reset state, then release so it is sampled at edge 2.
        goto(1);
        chk("rst_up",    int'(nav.up),    0);
        chk("rst_down",  int'(nav.down),  0);
        chk("rst_right", int'(nav.right), 0);
        chk("rst_left",  int'(nav.left),  0);
        chk("rst_held",  int'(nav.held),  0);
        rst_n = 1'b1;

        // Single press: right from edge 10 for 30 cycles.
        goto(9);  nav.btn_right_raw = 1'b1;
        expect_mv(17, 4'b0100);
        goto(15); chk("t1_held_pre",  int'(nav.held), 0);
        goto(16); chk("t1_held_rise", int'(nav.held), 1);
        goto(39); nav.btn_right_raw = 1'b0;
        goto(45); chk("t1_held_hold", int'(nav.held), 1);
        goto(46); chk("t1_held_fall", int'(nav.held), 0);

        // Bounce: up toggles every 2 cycles, then settles high at edge 80.
        for (int i = 0; i < 10; i++) begin
            goto(59 + 2 * i);
            nav.btn_up_raw = (i % 2 == 0);
        end
        goto(79); nav.btn_up_raw = 1'b1;
        expect_mv(87, 4'b0001);
        goto(99); nav.btn_up_raw = 1'b0;

        // Simultaneous up+left: up wins; left alone never fires until re-pressed.
        goto(119); nav.btn_up_raw = 1'b1; nav.btn_left_raw = 1'b1;
        expect_mv(127, 4'b0001);
        goto(139); nav.btn_up_raw = 1'b0;
        goto(150); chk("t3_held_left", int'(nav.held), 1);
        goto(159); nav.btn_left_raw = 1'b0;
        goto(166); chk("t3_held_off", int'(nav.held), 0);
        goto(179); nav.btn_left_raw = 1'b1;
        expect_mv(187, 4'b1000);
        goto(189); nav.btn_left_raw = 1'b0;

        // Enable gating: press while disabled never fires.
        goto(199); nav.en = 1'b0;
        goto(209); nav.btn_down_raw = 1'b1;
        goto(220); chk("t4_held_dis", int'(nav.held), 1);
        goto(224); nav.en = 1'b1;
        goto(234); nav.btn_down_raw = 1'b0;
        goto(259); nav.btn_down_raw = 1'b1;
        expect_mv(267, 4'b0010);
        goto(274); nav.btn_down_raw = 1'b0;

        // en dropped during FIRE cancels the pulse immediately.
        goto(299); nav.btn_right_raw = 1'b1;
        goto(306); @(posedge clk25MHz); #1 nav.en = 1'b0;
        #1 chk("t5_fire_cancel", int'(nav.right), 0);
        chk("t5_held", int'(nav.held), 1);
        goto(309); nav.en = 1'b1;
        goto(314); nav.btn_right_raw = 1'b0;

        // Reset during FIRE; button still held afterwards re-debounces and fires.
        goto(339); nav.btn_down_raw = 1'b1;
        goto(346); @(posedge clk25MHz); #1 rst_n = 1'b0;
        #1 chk("t6_rst_down", int'(nav.down), 0);
        chk("t6_rst_held", int'(nav.held), 0);
        goto(359); rst_n = 1'b1;
        expect_mv(369, 4'b0010);
        goto(367); chk("t6_held_pre",  int'(nav.held), 0);
        goto(368); chk("t6_held_rise", int'(nav.held), 1);
        goto(379); nav.btn_down_raw = 1'b0;

        // Long left hold: single pulse, plus repeats when auto-repeat is built.
        goto(399); nav.btn_left_raw = 1'b1;
        expect_mv(407, 4'b1000);
`ifdef AUTO_REPEAT_EN
        expect_mv(427, 4'b1000);
        expect_mv(435, 4'b1000);
        expect_mv(443, 4'b1000);
        expect_mv(451, 4'b1000);
        expect_mv(459, 4'b1000);
`endif
        goto(459); nav.btn_left_raw = 1'b0;
        goto(466); chk("t7_held_off", int'(nav.held), 0);
        goto(490);

        chk("missing_pulses", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nav_button_events.md
Name: nav_button_events

Overview:
- Converts the four raw board push-buttons (up/down/right/left) into clean, mutually exclusive, single-cycle move pulses.
- These pulses drive the cursor/selection step blocks of the colour-matching game.
- Per button: synchroniser, then debounce, then press-edge detect.
- A small arbiter FSM emits at most one move per physical press and holds off until every button is released.

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles a synchronised level must stay constant before it is accepted (10 ms at 25 MHz); legal range is 2 or more.
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 12500000, cycles held before the first auto-repeat (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeats (used only with AUTO_REPEAT_EN).

Ports:
- clk25MHz  in  1  system clock, 25 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  move generation enable, driven high by the game step sequencer while a cursor phase is active.
- btn_up_raw, btn_down_raw, btn_right_raw, btn_left_raw  in  1 each  raw, asynchronous, active-high buttons.
- up, down, right, left  out  1 each  one-cycle move pulses; at most one is high in any cycle.
- held  out  1  high while any debounced button is pressed.

Behaviour:
- Reset: all synchroniser flops, debounced levels, counters, outputs and held are 0; FSM is in IDLE. Reset is async assert, sync release.
- Synchroniser: two flops per button. No logic reads the first stage.
- Debounce, per button, with stable level S and counter C:
  - When sync equals S, C is cleared to 0.
  - Otherwise C increments each cycle.
  - When C = DEBOUNCE_CYCLES-1 while sync still differs from S, S takes sync and C is cleared.
  - A glitch shorter than DEBOUNCE_CYCLES never changes S.
- Press edge: high for exactly one cycle when S goes 0 to 1.
- Latency: raw held high from edge k produces the move pulse at edge k+DEBOUNCE_CYCLES+3. Outputs are registered.
- FSM states IDLE, FIRE, HELD:
  - IDLE to FIRE when en=1 and any press edge occurs. The winner is latched by priority up > down > right > left; simultaneous edges for other buttons are discarded.
  - FIRE lasts exactly one cycle. The winner's output is 1 and the FSM then goes to HELD.
  - HELD to IDLE when all four S are 0. A new press of another button while in HELD is ignored.
- Outputs are 0 in every state except FIRE. held = OR of the four S, independent of en.
- en=0:
  - Outputs are forced to 0 the same cycle.
  - The FSM goes to HELD if any S=1, else to IDLE. A press made while disabled never fires after en rises; the button must be released first.
  - en=0 during FIRE cancels the pulse.
- Counter width: comparison uses CNT_W bits. DEBOUNCE_CYCLES exceeding 2^CNT_W-1 is a configuration error, checked by an elaboration-time assertion.
- A button released and re-pressed within one debounce window yields no event. This is by design.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- With it defined:
  - In HELD, when exactly one S is high and it is the last fired direction, a repeat counter runs.
  - At REPEAT_DELAY the FSM re-enters FIRE for that direction, then again every REPEAT_PERIOD.
  - Any change in the set of pressed buttons, or en=0, clears the counter.
- Without it: no repeat counter is built and the FSM never leaves HELD until all buttons are released.

Decomposition:
- Shared package game_pkg holds:
  - direction encoding dir_t (UP=0, DOWN=1, RIGHT=2, LEFT=3) and the priority order;
  - FSM state encoding (IDLE=2'b00, FIRE=2'b01, HELD=2'b10);
  - the 25 MHz clock constant used to derive cycle counts.
- One sub-module, debounce_cell (synchroniser, counter, stable level, press-edge output), parameterised by DEBOUNCE_CYCLES/CNT_W and instantiated four times.
- Arbiter FSM and repeat logic stay in nav_button_events.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8 for simulation):
- Single press: btn_right_raw high at edge 10, held 30 cycles, en=1 -> right=1 only at edge 17 and never again; held rises at edge 16 and falls 6 edges after release.
- Bounce: btn_up_raw toggles every 2 cycles for 20 cycles, then settles high -> exactly one up pulse, 7 edges after the final settle; no pulse during the bounce.
- Simultaneous press: up and left raw high at the same edge -> one up pulse, no left pulse; then release up while keeping left -> still no left pulse until all buttons are released and left is pressed again.
- Enable gating: press down with en=0, raise en while down is held, release, then press down again -> zero pulses for the first press, one pulse for the second.
- Reset mid-operation: assert rst_n=0 during FIRE -> down=0 immediately (async) and held=0; after release with the button still held, a full debounce window must elapse and a pulse is issued.
- AUTO_REPEAT_EN: hold left 60 cycles after debounce -> left pulses at fire, fire+20, fire+28, fire+36, ...; without the macro -> a single pulse.
